// File: rtl/pid_axis_sched.sv
// pid_axis_sched: two-axis incremental-PID scheduler for the pan/tilt loop.
// One shared term unit is time-multiplexed between X and Y. Each axis keeps
// its error history and a saturated servo command.
// Optional feature: define PID_DEADBAND_EN to zero samples with |e| <= DEADBAND.
//
// state | meaning
// IDLE  | nothing pending, waiting for a strobe
// LOAD  | latch e0/e1/e2 and gains for the granted axis, clear its pending flag
// CALC  | register the term unit output d
// ACC   | accumulate d into uk with clamping, shift history, pulse upd
module pid_axis_sched #(
  parameter int UK_INIT  = 1500,
  parameter int UK_MIN   = 500,
  parameter int UK_MAX   = 2500,
  parameter int DEADBAND = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               clr,
  input  logic signed [9:0]  err_x,
  input  logic signed [9:0]  err_y,
  input  logic               vld_x,
  input  logic               vld_y,
  input  logic        [3:0]  kp,
  input  logic        [3:0]  ki,
  input  logic        [3:0]  kd,
  output logic signed [15:0] uk_x,
  output logic signed [15:0] uk_y,
  output logic               upd_x,
  output logic               upd_y,
  output logic               sat_x,
  output logic               sat_y,
  output logic               ovr,
  output logic               busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_ACC  = 2'd3;

`ifdef PID_DEADBAND_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  // A negative threshold can never be met, so the deadband folds away when disabled.
  localparam int DB_THR = DB_EN ? DEADBAND : -1;

  localparam logic signed [16:0] UK_MIN17 = 17'(UK_MIN);
  localparam logic signed [16:0] UK_MAX17 = 17'(UK_MAX);

  logic        [1:0]  state_q, state_d;
  logic               grant_q, grant_d;   // axis in flight: 0 = X, 1 = Y
  logic               ptr_q, ptr_d;       // last-served axis
  logic        [1:0]  pend_q, pend_d;     // bit0 = X, bit1 = Y
  logic signed [9:0]  buf_x_q, buf_x_d, buf_y_q, buf_y_d;
  logic signed [9:0]  e1_x_q, e1_x_d, e2_x_q, e2_x_d;
  logic signed [9:0]  e1_y_q, e1_y_d, e2_y_q, e2_y_d;
  logic signed [9:0]  e0_q, e0_d, e1_q, e1_d, e2_q, e2_d;
  logic        [3:0]  kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic signed [14:0] d_q, d_d;
  logic signed [15:0] uk_x_q, uk_x_d, uk_y_q, uk_y_d;
  logic               upd_x_q, upd_x_d, upd_y_q, upd_y_d;
  logic               sat_x_q, sat_x_d, sat_y_q, sat_y_d;
  logic               ovr_q, ovr_d;

  logic        [1:0]  req;
  logic               pick;
  logic signed [14:0] p_term, i_term, d_term, d_calc;
  logic signed [15:0] uk_sel, uk_new;
  logic signed [16:0] acc_sum;
  logic               acc_hi, acc_lo;

  function automatic logic signed [9:0] dband(input logic signed [9:0] e);
    logic signed [11:0] mag;
    mag = e[9] ? -12'(e) : 12'(e);
    return (int'(mag) <= DB_THR) ? 10'sd0 : e;
  endfunction

  // A strobe in the arbitration cycle counts as a request so IDLE reacts immediately.
  assign req  = pend_q | {vld_y, vld_x};
  assign pick = (req == 2'b11) ? ~ptr_q : req[1];

  // 15-bit wrap-around arithmetic gives the low bits of the exact result directly.
  assign p_term = 15'($signed({1'b0, kp_q})) * (15'(e0_q) - 15'(e1_q));
  assign i_term = 15'($signed({1'b0, ki_q})) * 15'(e0_q);
  assign d_term = 15'($signed({1'b0, kd_q})) * (15'(e0_q) - (15'(e1_q) <<< 1) + 15'(e2_q));
  assign d_calc = p_term + i_term + d_term;

  assign uk_sel  = grant_q ? uk_y_q : uk_x_q;
  assign acc_sum = 17'(uk_sel) + 17'(d_q);
  assign acc_hi  = acc_sum > UK_MAX17;
  assign acc_lo  = acc_sum < UK_MIN17;
  assign uk_new  = acc_hi ? 16'(UK_MAX) : (acc_lo ? 16'(UK_MIN) : acc_sum[15:0]);

  // Next-state: sample capture, pending/overrun tracking and the LOAD/CALC/ACC sequence.
  always_comb begin
    state_d = state_q;  grant_d = grant_q;  ptr_d = ptr_q;  pend_d = pend_q;
    buf_x_d = buf_x_q;  buf_y_d = buf_y_q;
    e1_x_d  = e1_x_q;   e2_x_d  = e2_x_q;   e1_y_d = e1_y_q;  e2_y_d = e2_y_q;
    e0_d    = e0_q;     e1_d    = e1_q;     e2_d   = e2_q;
    kp_d    = kp_q;     ki_d    = ki_q;     kd_d   = kd_q;    d_d    = d_q;
    uk_x_d  = uk_x_q;   uk_y_d  = uk_y_q;   sat_x_d = sat_x_q; sat_y_d = sat_y_q;
    ovr_d   = ovr_q;    upd_x_d = 1'b0;     upd_y_d = 1'b0;

    // The sample being latched in LOAD is consumed, so a new strobe then is not an overrun.
    if (state_q == S_LOAD) pend_d[grant_q] = 1'b0;
    if (vld_x) begin
      if (pend_d[0]) ovr_d = 1'b1;
      pend_d[0] = 1'b1;
      buf_x_d   = err_x;
    end
    if (vld_y) begin
      if (pend_d[1]) ovr_d = 1'b1;
      pend_d[1] = 1'b1;
      buf_y_d   = err_y;
    end

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d = pick;
          ptr_d   = pick;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        e0_d    = dband(grant_q ? buf_y_q : buf_x_q);
        e1_d    = grant_q ? e1_y_q : e1_x_q;
        e2_d    = grant_q ? e2_y_q : e2_x_q;
        kp_d    = kp;
        ki_d    = ki;
        kd_d    = kd;
        state_d = S_CALC;
      end
      S_CALC: begin
        d_d     = d_calc;
        state_d = S_ACC;
      end
      S_ACC: begin
        if (grant_q) begin
          uk_y_d  = uk_new;
          sat_y_d = acc_hi | acc_lo;
          e2_y_d  = e1_y_q;
          e1_y_d  = e0_q;
          upd_y_d = 1'b1;
        end else begin
          uk_x_d  = uk_new;
          sat_x_d = acc_hi | acc_lo;
          e2_x_d  = e1_x_q;
          e1_x_d  = e0_q;
          upd_x_d = 1'b1;
        end
        if (|req) begin
          grant_d = pick;
          ptr_d   = pick;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; clr behaves exactly like reset and drops any strobe in that cycle.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || clr) begin
      state_q <= S_IDLE;  grant_q <= 1'b0;  ptr_q <= 1'b1;  pend_q <= 2'b00;
      buf_x_q <= '0;      buf_y_q <= '0;
      e1_x_q  <= '0;      e2_x_q  <= '0;    e1_y_q <= '0;   e2_y_q <= '0;
      e0_q    <= '0;      e1_q    <= '0;    e2_q   <= '0;
      kp_q    <= '0;      ki_q    <= '0;    kd_q   <= '0;   d_q    <= '0;
      uk_x_q  <= 16'(UK_INIT);  uk_y_q <= 16'(UK_INIT);
      upd_x_q <= 1'b0;    upd_y_q <= 1'b0;
      sat_x_q <= 1'b0;    sat_y_q <= 1'b0;  ovr_q  <= 1'b0;
    end else begin
      state_q <= state_d; grant_q <= grant_d; ptr_q <= ptr_d; pend_q <= pend_d;
      buf_x_q <= buf_x_d; buf_y_q <= buf_y_d;
      e1_x_q  <= e1_x_d;  e2_x_q  <= e2_x_d;  e1_y_q <= e1_y_d; e2_y_q <= e2_y_d;
      e0_q    <= e0_d;    e1_q    <= e1_d;    e2_q   <= e2_d;
      kp_q    <= kp_d;    ki_q    <= ki_d;    kd_q   <= kd_d;   d_q    <= d_d;
      uk_x_q  <= uk_x_d;  uk_y_q  <= uk_y_d;
      upd_x_q <= upd_x_d; upd_y_q <= upd_y_d;
      sat_x_q <= sat_x_d; sat_y_q <= sat_y_d; ovr_q  <= ovr_d;
    end
  end

  assign uk_x  = uk_x_q;
  assign uk_y  = uk_y_q;
  assign upd_x = upd_x_q;
  assign upd_y = upd_y_q;
  assign sat_x = sat_x_q;
  assign sat_y = sat_y_q;
  assign ovr   = ovr_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_pid_axis_sched.sv
// Bench for pid_axis_sched: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a job-timeline model.
module tb_pid_axis_sched;
  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic               clr = 1'b0;
  logic signed [9:0]  err_x = '0, err_y = '0;
  logic               vld_x = 1'b0, vld_y = 1'b0;
  logic        [3:0]  kp = '0, ki = '0, kd = '0;
  logic signed [15:0] uk_x, uk_y;
  logic               upd_x, upd_y, sat_x, sat_y, ovr, busy;

  always #5 sys_clk = ~sys_clk;

  pid_axis_sched dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clr(clr),
    .err_x(err_x), .err_y(err_y), .vld_x(vld_x), .vld_y(vld_y),
    .kp(kp), .ki(ki), .kd(kd),
    .uk_x(uk_x), .uk_y(uk_y), .upd_x(upd_x), .upd_y(upd_y),
    .sat_x(sat_x), .sat_y(sat_y), .ovr(ovr), .busy(busy)
  );

  int n_cmp = 0, n_bad = 0;

  // Behavioural model: one shared server processes jobs on a fixed timeline
  // (grant at t, sample/gains captured at t+1, command written at t+3).
  int m_uk[2]   = '{1500, 1500};
  int m_h1[2]   = '{0, 0};
  int m_h2[2]   = '{0, 0};
  int m_buf[2]  = '{0, 0};
  bit m_pend[2] = '{0, 0};
  bit m_sat[2]  = '{0, 0};
  bit m_upd[2]  = '{0, 0};
  bit m_ovr = 0, m_last_y = 1, job_on = 0;
  int job_ax = 0, job_load = 0, job_done = 0, t = 0;
  int c_e0, c_e1, c_e2, c_kp, c_ki, c_kd;

  function automatic int dbm(int e);
`ifdef PID_DEADBAND_EN
    return ((e < 0 ? -e : e) <= 2) ? 0 : e;
`else
    return e;
`endif
  endfunction

  function automatic int wrap15(int v);
    logic [31:0] b;
    b = v;
    return int'($signed(b[14:0]));
  endfunction

  always @(posedge sys_clk) begin : model
    int ex[2];
    bit vv[2];
    int d, s;
    t++;
    vv[0] = vld_x; vv[1] = vld_y;
    ex[0] = int'(err_x); ex[1] = int'(err_y);
    m_upd[0] = 0; m_upd[1] = 0;
    if (!sys_rst_n || clr) begin
      for (int a = 0; a < 2; a++) begin
        m_uk[a] = 1500; m_h1[a] = 0; m_h2[a] = 0; m_buf[a] = 0;
        m_pend[a] = 0; m_sat[a] = 0;
      end
      m_ovr = 0; m_last_y = 1; job_on = 0;
    end else begin
      if (job_on && t == job_load) begin
        c_e0 = dbm(m_buf[job_ax]); c_e1 = m_h1[job_ax]; c_e2 = m_h2[job_ax];
        c_kp = int'(kp); c_ki = int'(ki); c_kd = int'(kd);
        m_pend[job_ax] = 0;
      end
      for (int a = 0; a < 2; a++) begin
        if (vv[a]) begin
          if (m_pend[a]) m_ovr = 1;
          m_pend[a] = 1;
          m_buf[a] = ex[a];
        end
      end
      if (job_on && t == job_done) begin
        d = wrap15(c_kp * (c_e0 - c_e1) + c_ki * c_e0 + c_kd * (c_e0 - 2 * c_e1 + c_e2));
        s = m_uk[job_ax] + d;
        m_sat[job_ax] = (s > 2500) || (s < 500);
        m_uk[job_ax] = (s > 2500) ? 2500 : (s < 500) ? 500 : s;
        m_h2[job_ax] = m_h1[job_ax];
        m_h1[job_ax] = c_e0;
        m_upd[job_ax] = 1;
        job_on = 0;
      end
      if (!job_on && (m_pend[0] || m_pend[1])) begin
        if (m_pend[0] && m_pend[1]) job_ax = m_last_y ? 0 : 1;
        else job_ax = m_pend[1] ? 1 : 0;
        m_last_y = (job_ax == 1);
        job_on = 1;
        job_load = t + 1;
        job_done = t + 3;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge sys_clk) begin
    n_cmp++;
    if (uk_x !== 16'(m_uk[0]) || uk_y !== 16'(m_uk[1]) || upd_x !== m_upd[0] ||
        upd_y !== m_upd[1] || sat_x !== m_sat[0] || sat_y !== m_sat[1] ||
        ovr !== m_ovr || busy !== job_on) begin
      n_bad++;
      $display("FAIL model t=%0d: got uk_x=%0d uk_y=%0d upd=%b%b sat=%b%b ovr=%b busy=%b; want uk_x=%0d uk_y=%0d upd=%b%b sat=%b%b ovr=%b busy=%b",
               t, uk_x, uk_y, upd_x, upd_y, sat_x, sat_y, ovr, busy,
               m_uk[0], m_uk[1], m_upd[0], m_upd[1], m_sat[0], m_sat[1], m_ovr, job_on);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic strobe(input bit sx, input int ex, input bit sy, input int ey);
    @(posedge sys_clk); #2;
    vld_x = sx; err_x = 10'(ex); vld_y = sy; err_y = 10'(ey);
    @(posedge sys_clk); #2;
    vld_x = 1'b0; vld_y = 1'b0;
  endtask

  task automatic do_clr();
    @(posedge sys_clk); #2 clr = 1'b1;
    @(posedge sys_clk); #2 clr = 1'b0;
  endtask

  task automatic gains(input int p, input int i, input int d);
    kp = 4'(p); ki = 4'(i); kd = 4'(d);
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
    chk("rst uk_x", int'(uk_x), 1500);
    chk("rst uk_y", int'(uk_y), 1500);
    chk("rst busy", int'(busy), 0);

    // First update after reset: d = 2*10 + 1*10 = 30.
    gains(2, 1, 0);
    strobe(1, 10, 0, 0);
    repeat (3) @(posedge sys_clk); #1;
    chk("t1 upd_x", int'(upd_x), 1);
    chk("t1 uk_x", int'(uk_x), 1530);
    chk("t1 sat_x", int'(sat_x), 0);
    chk("t1 uk_y", int'(uk_y), 1500);
    @(posedge sys_clk); #1;
    chk("t1 upd_x pulse", int'(upd_x), 0);

    // Tie after clear: X first, Y three edges later.
    do_clr();
    gains(1, 1, 1);
    strobe(1, 10, 1, -4);
    repeat (3) @(posedge sys_clk); #1;
    chk("tie upd_x", int'(upd_x), 1);
    chk("tie upd_y early", int'(upd_y), 0);
    chk("tie uk_x", int'(uk_x), 1530);
    repeat (3) @(posedge sys_clk); #1;
    chk("tie upd_y", int'(upd_y), 1);
    chk("tie uk_y", int'(uk_y), 1488);

    // After X alone was served, a tie goes to Y.
    do_clr();
    strobe(1, 1, 0, 0);
    repeat (5) @(posedge sys_clk);
    strobe(1, 2, 1, 3);
    repeat (3) @(posedge sys_clk); #1;
    chk("rr upd_y", int'(upd_y), 1);
    chk("rr uk_y", int'(uk_y), 1509);
    repeat (3) @(posedge sys_clk); #1;
    chk("rr upd_x", int'(upd_x), 1);
    chk("rr uk_x", int'(uk_x), 1506);

    // Saturation at the top and recovery.
    do_clr();
    gains(0, 1, 0);
    strobe(1, 495, 0, 0); repeat (4) @(posedge sys_clk);
    strobe(1, 495, 0, 0); repeat (3) @(posedge sys_clk); #1;
    chk("sat pre uk_x", int'(uk_x), 2490);
    strobe(1, 30, 0, 0); repeat (3) @(posedge sys_clk); #1;
    chk("sat uk_x", int'(uk_x), 2500);
    chk("sat sat_x", int'(sat_x), 1);
    strobe(1, -5, 0, 0); repeat (3) @(posedge sys_clk); #1;
    chk("unsat uk_x", int'(uk_x), 2495);
    chk("unsat sat_x", int'(sat_x), 0);

    // Overrun: two X strobes while Y is in flight, latest sample wins.
    do_clr();
    @(posedge sys_clk); #2 vld_y = 1'b1; err_y = 10'sd1;
    @(posedge sys_clk); #2 vld_y = 1'b0; vld_x = 1'b1; err_x = 10'sd5;
    @(posedge sys_clk); #2 err_x = 10'sd7;
    @(posedge sys_clk); #2 vld_x = 1'b0;
    chk("ovr set", int'(ovr), 1);
    repeat (4) @(posedge sys_clk); #1;
    chk("ovr upd_x", int'(upd_x), 1);
    chk("ovr uk_x", int'(uk_x), 1507);

    // clr while the X update is in CALC aborts it.
    do_clr();
    strobe(1, 10, 0, 0);
    @(posedge sys_clk); #2 clr = 1'b1;
    @(posedge sys_clk); #1;
    chk("abort busy", int'(busy), 0);
    chk("abort uk_x", int'(uk_x), 1500);
    #1 clr = 1'b0;
    @(posedge sys_clk); #1;
    chk("abort upd_x", int'(upd_x), 0);
    gains(1, 0, 0);
    strobe(1, 4, 0, 0); repeat (3) @(posedge sys_clk); #1;
    chk("abort hist", int'(uk_x), 1504);

    // Deadband behaviour on small errors.
    do_clr();
    gains(0, 1, 0);
    strobe(1, 2, 0, 0); repeat (3) @(posedge sys_clk); #1;
    chk("db upd_x", int'(upd_x), 1);
`ifdef PID_DEADBAND_EN
    chk("db uk_x e2", int'(uk_x), 1500);
`else
    chk("db uk_x e2", int'(uk_x), 1502);
`endif
    strobe(1, 3, 0, 0); repeat (3) @(posedge sys_clk); #1;
`ifdef PID_DEADBAND_EN
    chk("db uk_x e3", int'(uk_x), 1503);
`else
    chk("db uk_x e3", int'(uk_x), 1505);
`endif

    // Randomized traffic, gains changes, clears and resets.
    for (int c = 0; c < 4000; c++) begin
      int e;
      @(posedge sys_clk); #2;
      vld_x = ($urandom % 4 == 0);
      vld_y = ($urandom % 4 == 0);
      e = ($urandom % 4 == 0) ? int'($signed(10'($urandom))) : int'($urandom_range(0, 40)) - 20;
      err_x = 10'(e);
      e = ($urandom % 4 == 0) ? int'($signed(10'($urandom))) : int'($urandom_range(0, 40)) - 20;
      err_y = 10'(e);
      if ($urandom % 40 == 0) gains($urandom % 16, $urandom % 16, $urandom % 16);
      clr = ($urandom % 300 == 0);
      sys_rst_n = !($urandom % 500 == 0);
    end
    @(posedge sys_clk); #2;
    vld_x = 1'b0; vld_y = 1'b0; clr = 1'b0; sys_rst_n = 1'b1;
    repeat (10) @(posedge sys_clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
